// File: rtl/dmem_pkg.sv
// Shared definitions for the processor data-memory bus and the
// memory-mapped game-I/O window that sits on top of it.
package dmem_pkg;

    localparam int DMEM_ADDR_W   = 12;
    localparam int DMEM_DATA_W   = 32;
    localparam int MMIO_WIN_BITS = 4;

    localparam logic [DMEM_ADDR_W-1:0] MMIO_BASE = 12'hF00;

    localparam logic [MMIO_WIN_BITS-1:0] OFS_P1_DIR    = 4'd0;
    localparam logic [MMIO_WIN_BITS-1:0] OFS_P2_DIR    = 4'd1;
    localparam logic [MMIO_WIN_BITS-1:0] OFS_GAME_CTRL = 4'd2;
    localparam logic [MMIO_WIN_BITS-1:0] OFS_SCORE     = 4'd3;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with occupancy count.
// Head is presented combinationally from storage; zero while empty.
module sync_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [LVL_W-1:0] level,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             do_pop;

    assign empty  = (level_q == '0);
    assign full   = (level_q == LVL_W'(DEPTH));
    assign do_pop = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        level_d = level_q + LVL_W'(push) - LVL_W'(do_pop);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // A push into a full FIFO only happens alongside a pop, so the slot
    // being overwritten is the one leaving this cycle.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = empty ? '0 : mem_q[rd_ptr_q];
    assign level = level_q;

endmodule

// File: rtl/dmem_store_capture.sv
// Snoops processor dmem stores, keeps those hitting the game-I/O window
// and queues them for the game/VGA logic.
module dmem_store_capture
    import dmem_pkg::*;
#(
    parameter int                ADDR_W    = DMEM_ADDR_W,
    parameter int                DATA_W    = DMEM_DATA_W,
    parameter logic [ADDR_W-1:0] BASE_ADDR = MMIO_BASE,
    parameter int                WIN_BITS  = MMIO_WIN_BITS,
    parameter int                DEPTH     = 8,
    localparam int               LVL_W     = $clog2(DEPTH) + 1,
    localparam int               WIDTH     = WIN_BITS + DATA_W
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                dmem_wren,
    input  logic [ADDR_W-1:0]   dmem_address,
    input  logic [DATA_W-1:0]   dmem_data_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIN_BITS-1:0] out_offset,
    output logic [DATA_W-1:0]   out_data,
    output logic [LVL_W-1:0]    level,
    output logic                overflow,
    output logic [7:0]          drop_count,
    input  logic                clr_overflow
);

    logic             hit;
    logic             pop;
    logic             push;
    logic             drop;
    logic             full;
    logic             empty;
    logic [WIDTH-1:0] head;
    logic             overflow_q, overflow_d;
    logic [7:0]       drop_count_q, drop_count_d;

    assign hit = dmem_wren &&
                 (dmem_address[ADDR_W-1:WIN_BITS] ==
                  BASE_ADDR[ADDR_W-1:WIN_BITS]);

    assign pop  = !empty && out_ready;
    assign push = hit && (!full || pop);
    assign drop = hit && full && !pop;

    sync_fifo #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clock(clock),
        .reset(reset),
        .push (push),
        .pop  (pop),
        .wdata({dmem_address[WIN_BITS-1:0], dmem_data_in}),
        .rdata(head),
        .level(level),
        .full (full),
        .empty(empty)
    );

    // A drop in the same cycle as a clear wins, restarting the count at 1.
    always_comb begin
        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;
        if (clr_overflow) begin
            overflow_d   = 1'b0;
            drop_count_d = 8'd0;
        end
        if (drop) begin
            overflow_d = 1'b1;
            if (clr_overflow) begin
                drop_count_d = 8'd1;
            end else if (drop_count_q != 8'hFF) begin
                drop_count_d = drop_count_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            overflow_q   <= 1'b0;
            drop_count_q <= 8'd0;
        end else begin
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign out_valid  = !empty;
    assign out_offset = head[WIDTH-1:DATA_W];
    assign out_data   = head[DATA_W-1:0];
    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_dmem_store_capture.sv
// Bench for dmem_store_capture: queue-based reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_dmem_store_capture;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        dmem_wren = 1'b0;
    logic [11:0] dmem_address = '0;
    logic [31:0] dmem_data_in = '0;
    logic        out_ready = 1'b0;
    logic        clr_overflow = 1'b0;
    logic        out_valid;
    logic [3:0]  out_offset;
    logic [31:0] out_data;
    logic [3:0]  level;
    logic        overflow;
    logic [7:0]  drop_count;

    int errors = 0;
    int checks = 0;

    dmem_store_capture dut (
        .clock       (clock),
        .reset       (reset),
        .dmem_wren   (dmem_wren),
        .dmem_address(dmem_address),
        .dmem_data_in(dmem_data_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_offset  (out_offset),
        .out_data    (out_data),
        .level       (level),
        .overflow    (overflow),
        .drop_count  (drop_count),
        .clr_overflow(clr_overflow)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of {offset,data} plus overflow state.
    logic [35:0] mq[$];
    bit          m_ov = 1'b0;
    int          m_dc = 0;
    bit          m_hit, m_drop;

    always @(posedge clock) begin
        if (!reset) begin
            mq.delete();
            m_ov = 1'b0;
            m_dc = 0;
        end else begin
            m_hit = dmem_wren && dmem_address >= 12'hF00 &&
                    dmem_address <= 12'hF0F;
            m_drop = 1'b0;
            if (out_ready && mq.size() != 0) void'(mq.pop_front());
            if (m_hit) begin
                if (mq.size() < 8)
                    mq.push_back({dmem_address[3:0], dmem_data_in});
                else
                    m_drop = 1'b1;
            end
            if (clr_overflow) begin
                m_ov = 1'b0;
                m_dc = 0;
            end
            if (m_drop) begin
                m_ov = 1'b1;
                if (m_dc < 255) m_dc++;
            end
        end
    end

    always @(negedge clock) begin
        chk("model_valid", 64'(out_valid), 64'(mq.size() != 0));
        chk("model_level", 64'(level), 64'(mq.size()));
        chk("model_overflow", 64'(overflow), 64'(m_ov));
        chk("model_drop_count", 64'(drop_count), 64'(m_dc));
        if (mq.size() != 0)
            chk("model_head", 64'({out_offset, out_data}), 64'(mq[0]));
    end

    task automatic step(input logic w, input logic [11:0] a,
                        input logic [31:0] d, input logic r,
                        input logic c = 1'b0, input logic rs = 1'b1);
        dmem_wren    = w;
        dmem_address = a;
        dmem_data_in = d;
        out_ready    = r;
        clr_overflow = c;
        reset        = rs;
        @(negedge clock);
    endtask

    task automatic drain();
        for (int i = 0; i < 10; i++) step(1'b0, 12'h0, 32'h0, 1'b1);
    endtask

    initial begin
        // Reset held with window stores active
        step(1'b1, 12'hF03, 32'hDEAD, 1'b0, 1'b0, 1'b0);
        step(1'b1, 12'hF04, 32'hBEEF, 1'b0, 1'b0, 1'b0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_drop_count", 64'(drop_count), 64'd0);
        chk("rst_offset", 64'(out_offset), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);

        // Single hit, held stable while not ready
        step(1'b1, 12'hF02, 32'h12345678, 1'b0);
        chk("t2_valid", 64'(out_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 12'hF02, 32'h0, 1'b0);
            chk("t2_hold_offset", 64'(out_offset), 64'd2);
            chk("t2_hold_data", 64'(out_data), 64'h12345678);
        end
        step(1'b0, 12'h0, 32'h0, 1'b1);
        chk("t2_drained", 64'(level), 64'd0);

        // Non-hits
        step(1'b1, 12'hEFF, 32'h1, 1'b0);
        step(1'b1, 12'h000, 32'h2, 1'b0);
        step(1'b1, 12'hF10, 32'h3, 1'b0);
        step(1'b0, 12'hF00, 32'h4, 1'b0);
        chk("t3_level", 64'(level), 64'd0);

        // Overflow with 10 hits
        for (int i = 1; i <= 10; i++)
            step(1'b1, 12'hF00 + 12'(i & 15), 32'(i), 1'b0);
        chk("t4_level", 64'(level), 64'd8);
        chk("t4_overflow", 64'(overflow), 64'd1);
        chk("t4_drop_count", 64'(drop_count), 64'd2);
        for (int i = 1; i <= 8; i++) begin
            chk("t4_order", 64'(out_data), 64'(i));
            step(1'b0, 12'h0, 32'h0, 1'b1);
        end
        chk("t4_empty", 64'(level), 64'd0);
        step(1'b0, 12'h0, 32'h0, 1'b0, 1'b1);
        chk("t4_clr_ov", 64'(overflow), 64'd0);
        chk("t4_clr_dc", 64'(drop_count), 64'd0);

        // Push+pop on full, then on empty
        for (int i = 0; i < 8; i++)
            step(1'b1, 12'hF07, 32'h100 + 32'(i), 1'b0);
        step(1'b1, 12'hF05, 32'hAAA, 1'b1);
        chk("t5_full_level", 64'(level), 64'd8);
        chk("t5_no_drop", 64'(overflow), 64'd0);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) chk("t5_last_out", 64'(out_data), 64'hAAA);
            step(1'b0, 12'h0, 32'h0, 1'b1);
        end
        step(1'b1, 12'hF06, 32'hBBB, 1'b1);
        chk("t5_empty_push", 64'(level), 64'd1);
        drain();

        // Drop counter saturation, then clear colliding with a drop
        for (int i = 0; i < 268; i++)
            step(1'b1, 12'hF0F, 32'(i), 1'b0);
        chk("sat_drop_count", 64'(drop_count), 64'd255);
        step(1'b1, 12'hF0F, 32'h0, 1'b0, 1'b1);
        chk("clr_drop_ov", 64'(overflow), 64'd1);
        chk("clr_drop_dc", 64'(drop_count), 64'd1);
        drain();
        step(1'b0, 12'h0, 32'h0, 1'b0, 1'b1);

        // Reset mid-drain
        for (int i = 0; i < 5; i++)
            step(1'b1, 12'hF03, 32'h50 + 32'(i), 1'b0);
        step(1'b0, 12'h0, 32'h0, 1'b1);
        step(1'b0, 12'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("t6_rst_valid", 64'(out_valid), 64'd0);
        step(1'b1, 12'hF01, 32'h77, 1'b0);
        chk("t6_offset", 64'(out_offset), 64'd1);
        chk("t6_data", 64'(out_data), 64'h77);
        chk("t6_level", 64'(level), 64'd1);
        drain();

        // Randomised traffic in phases of differing consumer speed
        for (int ph = 0; ph < 4; ph++) begin
            for (int i = 0; i < 1000; i++) begin
                logic        w, r, c, rs;
                logic [11:0] a;
                w  = ($urandom % 4) != 0;
                a  = ($urandom % 3 != 0) ? 12'hF00 + 12'($urandom % 16)
                                         : 12'($urandom);
                r  = ($urandom % 4) < ph;
                c  = ($urandom % 60) == 0;
                rs = ($urandom % 300) != 0;
                step(w, a, $urandom, r, c, rs);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
